seq_pattern_tx: RTL and testbench

//  Serial bit-pattern generator. Emits a PAT_W-bit pattern MSB-first on pout, one bit per clk.

---
 rtl/seq_pattern_tx.sv | 137 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern generator: sends a PAT_W-bit pattern MSB-first, rep+1 times,
// with GAP_LEN idle cycles between frames. All outputs are registered.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1101,
  parameter int               CNT_W   = 4,
  parameter int               GAP_LEN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep,
  input  logic             abort,
  output logic             pout,
  output logic             pvalid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = (GAP_LEN > 1) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] pat, pat_d;
  logic [BIT_W-1:0] bit_idx, bit_d;
  logic [CNT_W-1:0] repcnt, rep_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic             pout_d, pvalid_d, sof_d, busy_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat     <= '0;
      bit_idx <= '0;
      repcnt  <= '0;
      gap_cnt <= '0;
      pout    <= 1'b0;
      pvalid  <= 1'b0;
      sof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      pat     <= pat_d;
      bit_idx <= bit_d;
      repcnt  <= rep_d;
      gap_cnt <= gap_d;
      pout    <= pout_d;
      pvalid  <= pvalid_d;
      sof     <= sof_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // bit_idx names the bit currently on pout; the gap counter counts down to zero.
  always_comb begin
    state_d  = state;
    pat_d    = pat;
    bit_d    = bit_idx;
    rep_d    = repcnt;
    gap_d    = gap_cnt;
    pout_d   = 1'b0;
    pvalid_d = 1'b0;
    sof_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          pat_d    = use_def ? DEF_PAT : pat_in;
          rep_d    = rep;
          bit_d    = BIT_MSB;
          pout_d   = pat_d[PAT_W-1];
          pvalid_d = 1'b1;
          sof_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_idx != '0) begin
          bit_d    = bit_idx - BIT_W'(1);
          pout_d   = pat[bit_d];
          pvalid_d = 1'b1;
          busy_d   = 1'b1;
        end else if (repcnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rep_d = repcnt - CNT_W'(1);
          if (GAP_LEN == 0) begin
            bit_d    = BIT_MSB;
            pout_d   = pat[PAT_W-1];
            pvalid_d = 1'b1;
            sof_d    = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = GAP_INIT;
            busy_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt == '0) begin
          state_d  = SHIFT;
          bit_d    = BIT_MSB;
          pout_d   = pat[PAT_W-1];
          pvalid_d = 1'b1;
          sof_d    = 1'b1;
          busy_d   = 1'b1;
        end else begin
          gap_d  = gap_cnt - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP_LEN 0 and 2) share stimulus and are
// compared each cycle against a frame-list model, plus a vector table and corner cases.
module tb_seq_pattern_tx;

  logic       clk, rst, start, use_def, abort;
  logic [3:0] pat_in, rep;
  logic       pout0, pvalid0, sof0, busy0, done0;
  logic       pout2, pvalid2, sof2, busy2, done2;
  logic [4:0] o0, o2;

  int n_chk = 0;
  int n_fail = 0;

  // Expected per-cycle output words {pout,pvalid,sof,busy,done} per instance
  logic [4:0] mq [0:1][$];
  logic [4:0] cur [0:1];

  seq_pattern_tx #(.PAT_W(4), .DEF_PAT(4'b1101), .CNT_W(4), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .use_def(use_def), .pat_in(pat_in),
    .rep(rep), .abort(abort), .pout(pout0), .pvalid(pvalid0), .sof(sof0),
    .busy(busy0), .done(done0));

  seq_pattern_tx #(.PAT_W(4), .DEF_PAT(4'b1101), .CNT_W(4), .GAP_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .use_def(use_def), .pat_in(pat_in),
    .rep(rep), .abort(abort), .pout(pout2), .pvalid(pvalid2), .sof(sof2),
    .busy(busy2), .done(done2));

  assign o0 = {pout0, pvalid0, sof0, busy0, done0};
  assign o2 = {pout2, pvalid2, sof2, busy2, done2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [4:0] act, logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (pout,pvalid,sof,busy,done) t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // A whole sequence is laid out as a list of cycles when start is accepted.
  task automatic model_step();
    logic [3:0] p;
    int gl;
    for (int i = 0; i < 2; i++) begin
      gl = (i == 0) ? 0 : 2;
      if (abort) begin
        mq[i].delete();
        cur[i] = '0;
      end else if (mq[i].size() > 0) begin
        cur[i] = mq[i].pop_front();
      end else if (start && !cur[i][1]) begin
        p = use_def ? 4'b1101 : pat_in;
        for (int f = 0; f <= int'(rep); f++) begin
          for (int b = 0; b < 4; b++)
            mq[i].push_back({p[3-b], 1'b1, (b == 0), 1'b1, 1'b0});
          if (f < int'(rep))
            for (int g = 0; g < gl; g++) mq[i].push_back(5'b00010);
        end
        mq[i].push_back(5'b00001);
        cur[i] = mq[i].pop_front();
      end else begin
        cur[i] = '0;
      end
    end
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_d0"}, o0, cur[0]);
    check({tag, "_d2"}, o2, cur[1]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    start = 1'b0;
    abort = 1'b0;
    while ((mq[0].size() > 0 || mq[1].size() > 0 || cur[0] != '0 || cur[1] != '0) && n < 200) begin
      step("drain");
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
  endtask

  typedef struct {
    logic       start;
    logic       use_def;
    logic [3:0] pat_in;
    logic [3:0] rep;
    logic       abort;
    logic [4:0] exp0;
  } vec_t;

  vec_t tbl [0:5];
  int sof_n, busy_n, done_n, sof2_n, busy2_n, done2_n;

  initial begin
    rst = 1'b1; start = 1'b0; use_def = 1'b0; abort = 1'b0; pat_in = '0; rep = '0;
    cur[0] = '0; cur[1] = '0;
    #2;
    check("reset_d0", o0, 5'b00000);
    check("reset_d2", o2, 5'b00000);
    #10 rst = 1'b0;
    step("idle");
    step("idle");

    // Test 1: default pattern, single frame, dut0 checked against fixed vectors
    tbl[0] = '{1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 5'b11110};
    tbl[1] = '{1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 5'b11010};
    tbl[2] = '{1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 5'b01010};
    tbl[3] = '{1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 5'b11010};
    tbl[4] = '{1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 5'b00001};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].start; use_def = tbl[i].use_def; pat_in = tbl[i].pat_in;
      rep = tbl[i].rep; abort = tbl[i].abort;
      step("t1");
      check($sformatf("t1_tbl%0d", i), o0, tbl[i].exp0);
    end
    drain();

    // Test 2: user pattern 1011, rep=2, gaps on dut2
    start = 1'b1; use_def = 1'b0; pat_in = 4'b1011; rep = 4'd2;
    sof2_n = 0; busy2_n = 0; done2_n = 0;
    for (int k = 0; k < 22; k++) begin
      step("t2");
      start = 1'b0;
      sof2_n += int'(o2[2]); busy2_n += int'(o2[1]); done2_n += int'(o2[0]);
    end
    check_int("t2_sof_count", sof2_n, 3);
    check_int("t2_busy_cycles", busy2_n, 16);
    check_int("t2_done_count", done2_n, 1);
    drain();

    // Test 3: start held high, back-to-back sequences on dut0
    start = 1'b1; use_def = 1'b1; rep = 4'd1;
    sof_n = 0; done_n = 0;
    for (int k = 0; k < 18; k++) begin
      step("t3");
      sof_n += int'(o0[2]); done_n += int'(o0[0]);
      if (k == 8) check_int("t3_first_done", int'(o0[0]), 1);
      if (k == 9) check_int("t3_restart_sof", int'(o0[2]), 1);
    end
    check_int("t3_sof_count", sof_n, 4);
    check_int("t3_done_count", done_n, 2);
    drain();

    // Test 4: inputs changed and start pulsed mid-sequence
    start = 1'b1; use_def = 1'b0; pat_in = 4'b1011; rep = 4'd1;
    sof_n = 0; done_n = 0;
    for (int k = 0; k < 15; k++) begin
      step("t4");
      start = (k >= 2 && k <= 4);
      if (k == 2) begin pat_in = 4'b0110; rep = 4'd3; use_def = 1'b1; end
      sof_n += int'(o0[2]); done_n += int'(o0[0]);
    end
    check_int("t4_sof_count", sof_n, 2);
    check_int("t4_done_count", done_n, 1);
    drain();

    // Test 5: abort on 3rd bit of frame 2 (dut0), then restart
    start = 1'b1; use_def = 1'b1; rep = 4'd2;
    step("t5");
    start = 1'b0;
    for (int k = 0; k < 6; k++) step("t5");
    abort = 1'b1;
    step("t5_abort");
    check_int("t5_pvalid_busy", int'({o0[3], o0[1]}), 0);
    abort = 1'b0;
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      step("t5_after");
      done_n += int'(o0[0]);
    end
    check_int("t5_no_done", done_n, 0);
    start = 1'b1; rep = 4'd0;
    step("t5_restart");
    check_int("t5_restart_sof", int'(o0[2]), 1);
    drain();

    // Boundary: rep all ones gives 16 frames
    start = 1'b1; use_def = 1'b1; rep = 4'hF;
    sof_n = 0; busy_n = 0; done_n = 0; busy2_n = 0;
    for (int k = 0; k < 100; k++) begin
      step("maxrep");
      start = 1'b0;
      sof_n += int'(o0[2]); busy_n += int'(o0[1]); done_n += int'(o0[0]);
      busy2_n += int'(o2[1]);
    end
    check_int("maxrep_sof", sof_n, 16);
    check_int("maxrep_busy0", busy_n, 64);
    check_int("maxrep_done", done_n, 1);
    check_int("maxrep_busy2", busy2_n, 94);
    drain();

    // Test 6: asynchronous reset mid-bit
    start = 1'b1; use_def = 1'b0; pat_in = 4'b1111; rep = 4'd3;
    step("t6");
    start = 1'b0;
    step("t6");
    step("t6");
    #2 rst = 1'b1;
    #1;
    check("t6_async_d0", o0, 5'b00000);
    check("t6_async_d2", o2, 5'b00000);
    mq[0].delete(); mq[1].delete(); cur[0] = '0; cur[1] = '0;
    #3 rst = 1'b0;
    for (int k = 0; k < 4; k++) step("t6_idle");
    start = 1'b1; use_def = 1'b1; rep = 4'd0;
    step("t6_restart");
    drain();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      start   = ($urandom_range(0, 3) == 0);
      use_def = 1'($urandom_range(0, 1));
      pat_in  = 4'($urandom);
      rep     = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      abort   = ($urandom_range(0, 39) == 0);
      step("rnd");
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
